// File: rtl/regbank_pkg.sv
// Shared encodings for the register-bank command master.
// Op codes, FSM state type and default bank geometry.
package regbank_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SWAP2,
    S_RESP
  } state_e;

endpackage

// File: rtl/regbank_cmd_master.sv
// Command-driven initiator for the 4x8 register bank.
// Runs WRITE/READ/ADD/SWAP and returns results on a response channel.
module regbank_cmd_master
  import regbank_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr_a,
  input  logic [AW-1:0] cmd_addr_b,
  input  logic [AW-1:0] cmd_addr_d,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data1,
  output logic [DW-1:0] rsp_data2,
  output logic [AW-1:0] rb_read_reg1,
  output logic [AW-1:0] rb_read_reg2,
  output logic [AW-1:0] rb_write_reg,
  output logic [DW-1:0] rb_write_data,
  output logic          rb_reg_write,
  input  logic [DW-1:0] rb_read_data1,
  input  logic [DW-1:0] rb_read_data2
);

  state_e        state;
  logic [1:0]    op_q;
  logic [AW-1:0] a_q;
  logic [AW-1:0] b_q;
  logic [AW-1:0] d_q;
  logic [DW-1:0] wdata_q;
  logic [DW:0]   sum;

  logic exec_wr;
  logic exec_add;
  logic exec_swp;
  logic in_swap2;

  assign sum = {1'b0, rb_read_data1}
             + {1'b0, rb_read_data2};

  assign exec_wr  = (state == S_EXEC)
                 && (op_q == OP_WRITE);
  assign exec_add = (state == S_EXEC)
                 && (op_q == OP_ADD);
  assign exec_swp = (state == S_EXEC)
                 && (op_q == OP_SWAP);
  assign in_swap2 = (state == S_SWAP2);

  assign rb_read_reg1 = a_q;
  assign rb_read_reg2 = b_q;

  // Write port decoded only from flops, so reset kills a pending write at once.
  always_comb begin
    rb_reg_write  = 1'b0;
    rb_write_reg  = '0;
    rb_write_data = '0;
    unique case (1'b1)
      exec_wr: begin
        rb_reg_write  = 1'b1;
        rb_write_reg  = d_q;
        rb_write_data = wdata_q;
      end
      exec_add: begin
        rb_reg_write  = 1'b1;
        rb_write_reg  = d_q;
        rb_write_data = sum[DW-1:0];
      end
      exec_swp: begin
        rb_reg_write  = 1'b1;
        rb_write_reg  = a_q;
        rb_write_data = rb_read_data2;
      end
      in_swap2: begin
        rb_reg_write  = 1'b1;
        rb_write_reg  = b_q;
        rb_write_data = rsp_data1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      d_q       <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            a_q       <= cmd_addr_a;
            b_q       <= cmd_addr_b;
            d_q       <= cmd_addr_d;
            wdata_q   <= cmd_wdata;
            cmd_ready <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (op_q)
            OP_WRITE: begin
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
            OP_READ: begin
              rsp_data1 <= rb_read_data1;
              rsp_data2 <= rb_read_data2;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
            OP_ADD: begin
              rsp_data1 <= sum[DW-1:0];
              rsp_data2 <= {{(DW-1){1'b0}}, sum[DW]};
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
            default: begin
              rsp_data1 <= rb_read_data1;
              rsp_data2 <= rb_read_data2;
              state     <= S_SWAP2;
            end
          endcase
        end
        S_SWAP2: begin
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_cmd_master.sv
// Directed bench for regbank_cmd_master with a behavioural 4x8 bank.
// Expected values are hand-computed constants.
module tb_regbank_cmd_master;
  import regbank_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr_a;
  logic [1:0] cmd_addr_b;
  logic [1:0] cmd_addr_d;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data1;
  logic [7:0] rsp_data2;
  logic [1:0] rb_read_reg1;
  logic [1:0] rb_read_reg2;
  logic [1:0] rb_write_reg;
  logic [7:0] rb_write_data;
  logic       rb_reg_write;
  logic [7:0] rb_read_data1;
  logic [7:0] rb_read_data2;

  logic [7:0] bank [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (rb_reg_write) bank[rb_write_reg] <= rb_write_data;

  assign rb_read_data1 = bank[rb_read_reg1];
  assign rb_read_data2 = bank[rb_read_reg2];

  regbank_cmd_master #(.DW(8), .AW(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr_a    (cmd_addr_a),
    .cmd_addr_b    (cmd_addr_b),
    .cmd_addr_d    (cmd_addr_d),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data1     (rsp_data1),
    .rsp_data2     (rsp_data2),
    .rb_read_reg1  (rb_read_reg1),
    .rb_read_reg2  (rb_read_reg2),
    .rb_write_reg  (rb_write_reg),
    .rb_write_data (rb_write_data),
    .rb_reg_write  (rb_reg_write),
    .rb_read_data1 (rb_read_data1),
    .rb_read_data2 (rb_read_data2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Present a command, wait (bounded) for cmd_ready, return #1 after accept.
  task automatic send(input logic [1:0] op,
                      input logic [1:0] a,
                      input logic [1:0] b,
                      input logic [1:0] d,
                      input logic [7:0] w);
    int n = 0;
    cmd_op     = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_addr_d = d;
    cmd_wdata  = w;
    cmd_valid  = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] d,
                    input logic [7:0] w);
    send(OP_WRITE, 2'd0, 2'd0, d, w);
    @(posedge clk);
    #1;
  endtask

  task automatic take_rsp(input string tag,
                          input logic [7:0] e1,
                          input logic [7:0] e2);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_d1"}, rsp_data1, e1);
    chk({tag, "_d2"}, rsp_data2, e2);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, rsp_valid, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_addr_d = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_d1", rsp_data1, 0);
    chk("rst_rsp_d2", rsp_data2, 0);
    chk("rst_we", rb_reg_write, 0);
    chk("rst_wdata", rb_write_data, 0);
    chk("rst_raddr1", rb_read_reg1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(OP_WRITE, 2'd0, 2'd0, 2'd2, 8'hA5);
    chk("wr_we", rb_reg_write, 1);
    chk("wr_reg", rb_write_reg, 2);
    chk("wr_data", rb_write_data, 8'hA5);
    chk("wr_busy", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("wr_we_off", rb_reg_write, 0);
    chk("wr_bank", bank[2], 8'hA5);
    chk("wr_norsp", rsp_valid, 0);
    chk("wr_ready", cmd_ready, 1);

    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    send(OP_READ, 2'd0, 2'd1, 2'd0, 8'h00);
    chk("rd_lat0", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("rd_lat1", rsp_valid, 1);
    take_rsp("rd", 8'h11, 8'h22);

    wr(2'd0, 8'hF0);
    wr(2'd1, 8'h20);
    send(OP_ADD, 2'd0, 2'd1, 2'd0, 8'h00);
    take_rsp("add", 8'h10, 8'h01);
    chk("add_bank", bank[0], 8'h10);

    wr(2'd2, 8'h3C);
    wr(2'd3, 8'hC3);
    send(OP_SWAP, 2'd2, 2'd3, 2'd0, 8'h00);
    take_rsp("swp", 8'h3C, 8'hC3);
    chk("swp_r2", bank[2], 8'hC3);
    chk("swp_r3", bank[3], 8'h3C);

    send(OP_SWAP, 2'd1, 2'd1, 2'd0, 8'h00);
    take_rsp("swpeq", 8'h20, 8'h20);
    chk("swpeq_r1", bank[1], 8'h20);

    send(OP_READ, 2'd2, 2'd3, 2'd0, 8'h00);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_d1", rsp_data1, 8'hC3);
      chk("stall_d2", rsp_data2, 8'h3C);
      chk("stall_busy", cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    take_rsp("stall", 8'hC3, 8'h3C);

    wr(2'd2, 8'h55);
    wr(2'd3, 8'hAA);
    send(OP_SWAP, 2'd2, 2'd3, 2'd0, 8'h00);
    @(posedge clk);
    #1;
    chk("swp2_we", rb_reg_write, 1);
    chk("swp2_reg", rb_write_reg, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_we", rb_reg_write, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort_r2", bank[2], 8'hAA);
    chk("abort_r3", bank[3], 8'hAA);
    chk("abort_norsp", rsp_valid, 0);

    send(OP_READ, 2'd3, 2'd0, 2'd0, 8'h00);
    take_rsp("post", 8'hAA, 8'h10);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
